// File: rtl/fetch_prefetch_buffer.sv
// fetch_prefetch_buffer: credit-limited in-order instruction prefetch FIFO with redirect flush and wrong-path drain
module fetch_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [15:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [15:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        StallD,
  output logic [15:0] instr_out,
  output logic [15:0] instr_pc,
  output logic        instr_valid
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t r_state, w_state_nx;
  logic [CW-1:0] r_occ, r_out, r_drop, w_drop_nx;
  logic [AW-1:0] r_twr, r_trd, r_iwr, r_ird;
  logic [15:0] r_fetch_pc;
  logic [15:0] r_tag [DEPTH];
  logic [15:0] r_idata [DEPTH];
  logic [15:0] r_ipc [DEPTH];
  logic w_accept, w_push, w_consume, w_credit;
  assign w_credit  = ({1'b0, r_occ} + {1'b0, r_out}) < CAP;
  assign w_accept  = imem_req_valid & imem_req_ready;
  assign w_consume = instr_valid & ~StallD;
  assign imem_req_addr = r_fetch_pc;
  assign instr_valid = r_occ != '0;
  assign instr_out   = instr_valid ? r_idata[r_ird] : 16'h0000;
  assign instr_pc    = instr_valid ? r_ipc[r_ird] : 16'h0000;
  // r_drop is zero in RUN and r_out is zero in DRAIN, so one expression covers both states
  always_comb begin
    imem_req_valid = rst && r_state == RUN && !redirect_valid && w_credit;
    w_push = r_state == RUN && imem_rsp_valid && !redirect_valid;
    w_drop_nx = redirect_valid ? r_drop + r_out - CW'(imem_rsp_valid && (r_drop | r_out) != '0)
                               : r_drop - CW'(imem_rsp_valid && r_drop != '0);
    w_state_nx = (w_drop_nx != '0) ? DRAIN : RUN;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= RUN;
    else r_state <= w_state_nx;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_occ <= '0;
      r_out <= '0;
      r_drop <= '0;
      r_twr <= '0;
      r_trd <= '0;
      r_iwr <= '0;
      r_ird <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_occ <= '0;
      r_out <= '0;
      r_drop <= w_drop_nx;
      r_twr <= '0;
      r_trd <= '0;
      r_iwr <= '0;
      r_ird <= '0;
    end else begin
      r_fetch_pc <= w_accept ? r_fetch_pc + PC_STEP : r_fetch_pc;
      r_occ <= r_occ + CW'(w_push) - CW'(w_consume);
      r_out <= r_out + CW'(w_accept) - CW'(w_push);
      r_drop <= w_drop_nx;
      r_twr <= r_twr + AW'(w_accept);
      r_trd <= r_trd + AW'(w_push);
      r_iwr <= r_iwr + AW'(w_push);
      r_ird <= r_ird + AW'(w_consume);
    end
  end
  always_ff @(posedge clk) begin
    if (w_accept) r_tag[r_twr] <= r_fetch_pc;
    if (w_push) begin
      r_idata[r_iwr] <= imem_rsp_data;
      r_ipc[r_iwr] <= r_tag[r_trd];
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb_fetch_prefetch_buffer: randomized bench against a queue-based model of the prefetch buffer
module tb_fetch_prefetch_buffer;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 0;
  logic imem_req_valid, instr_valid;
  logic [15:0] imem_req_addr, instr_out, instr_pc;
  logic imem_req_ready = 0, imem_rsp_valid = 0, redirect_valid = 0, StallD = 0;
  logic [15:0] imem_rsp_data = 0, redirect_pc = 0;
  logic imem_req_valid2, instr_valid2;
  logic [15:0] imem_req_addr2, instr_out2, instr_pc2;
  logic imem_rsp_valid2 = 0;
  logic [15:0] imem_rsp_data2 = 0;
  typedef struct {logic [15:0] data; logic [15:0] pc;} ent_t;
  typedef struct {logic [15:0] addr; int due;} mreq_t;
  ent_t fifo[$];
  logic [15:0] inflight[$];
  mreq_t mem[$];
  int drop, cyc, lat, checks, errors;
  logic [15:0] fpc, e_io, e_ip;
  logic e_iv, e_rv;
  always #5 clk = ~clk;
  fetch_prefetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .StallD(StallD),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid));
  fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .rst(rst), .imem_req_valid(imem_req_valid2), .imem_req_addr(imem_req_addr2),
    .imem_req_ready(1'b1), .imem_rsp_valid(imem_rsp_valid2), .imem_rsp_data(imem_rsp_data2),
    .redirect_valid(1'b0), .redirect_pc(16'h0000), .StallD(1'b0),
    .instr_out(instr_out2), .instr_pc(instr_pc2), .instr_valid(instr_valid2));
  function automatic logic [15:0] f(input logic [15:0] a);
    return (a * 16'd37) ^ 16'hC3A5;
  endfunction
  task automatic drive(input bit redir, input logic [15:0] rpc, input bit stall, input bit ready, input bit rgate);
    redirect_valid = redir;
    redirect_pc = rpc;
    StallD = stall;
    imem_req_ready = ready;
    imem_rsp_valid = 1'b0;
    if (mem.size() > 0) imem_rsp_valid = mem[0].due <= cyc && rgate;
    if (imem_rsp_valid) imem_rsp_data = f(mem[0].addr);
    else imem_rsp_data = 16'($urandom);
    e_iv = fifo.size() != 0;
    e_io = e_iv ? fifo[0].data : 16'h0000;
    e_ip = e_iv ? fifo[0].pc : 16'h0000;
    e_rv = drop == 0 && !redir && fifo.size() + inflight.size() < DEPTH;
    #1;
  endtask
  task automatic advance();
    logic [15:0] p, a2;
    logic v2;
    if (imem_rsp_valid) mem.delete(0);
    if (imem_req_valid && imem_req_ready) mem.push_back('{imem_req_addr, cyc + lat});
    if (redirect_valid) begin
      if (imem_rsp_valid) begin
        if (drop > 0) drop--;
        else if (inflight.size() > 0) inflight.delete(0);
      end
      drop += inflight.size();
      inflight.delete();
      fifo.delete();
      fpc = redirect_pc;
    end else begin
      if (e_iv && !StallD) fifo.delete(0);
      if (imem_rsp_valid) begin
        if (drop > 0) drop--;
        else if (inflight.size() > 0) begin
          p = inflight[0];
          inflight.delete(0);
          fifo.push_back('{f(p), p});
        end
      end
      if (e_rv && imem_req_ready) begin
        inflight.push_back(fpc);
        fpc = fpc + 16'h0001;
      end
    end
    v2 = imem_req_valid2;
    a2 = imem_req_addr2;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    imem_rsp_valid2 = v2;
    imem_rsp_data2 = f(a2);
  endtask
  task automatic test_reset();
    imem_req_ready = 1;
    #1;
    checks += 2;
    if ({instr_valid, instr_out, instr_pc, imem_req_valid} !== 34'h0) begin
      errors++;
      $display("FAIL reset_out: got %b %h %h %b want all zero", instr_valid, instr_out, instr_pc, imem_req_valid);
    end
    if ({instr_valid2, instr_pc2, imem_req_valid2} !== 18'h0) begin
      errors++;
      $display("FAIL reset_out2: got %b %h %b want all zero", instr_valid2, instr_pc2, imem_req_valid2);
    end
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: req_valid got %b want 0", imem_req_valid);
    end
    rst = 1;
    fpc = 16'h0000;
    drop = 0;
    cyc = 0;
    lat = 1;
  endtask
  task automatic test_basic();
    for (int i = 0; i < 12; i++) begin
      drive(0, 16'h0, 0, 1, 1);
      checks += 2;
      if ({instr_valid, instr_out, instr_pc} !== {e_iv, e_io, e_ip}) begin
        errors++;
        $display("FAIL basic_instr: got %b %h %h want %b %h %h", instr_valid, instr_out, instr_pc, e_iv, e_io, e_ip);
      end
      if ({imem_req_valid, imem_req_valid ? imem_req_addr : 16'h0} !== {e_rv, e_rv ? fpc : 16'h0}) begin
        errors++;
        $display("FAIL basic_req: got %b %h want %b %h", imem_req_valid, imem_req_addr, e_rv, fpc);
      end
      advance();
    end
  endtask
  task automatic test_stall();
    for (int i = 0; i < 21; i++) begin
      drive(0, 16'h0, i < 11, 1, 1);
      checks += 2;
      if ({instr_valid, instr_out, instr_pc} !== {e_iv, e_io, e_ip}) begin
        errors++;
        $display("FAIL stall_instr: got %b %h %h want %b %h %h", instr_valid, instr_out, instr_pc, e_iv, e_io, e_ip);
      end
      if ({imem_req_valid, imem_req_valid ? imem_req_addr : 16'h0} !== {e_rv, e_rv ? fpc : 16'h0}) begin
        errors++;
        $display("FAIL stall_req: got %b %h want %b %h", imem_req_valid, imem_req_addr, e_rv, fpc);
      end
      if (i == 10) begin
        checks++;
        if ({imem_req_valid, instr_valid} !== 2'b01) begin
          errors++;
          $display("FAIL stall_cap: got req_valid %b instr_valid %b want 0 1", imem_req_valid, instr_valid);
        end
      end
      advance();
    end
  endtask
  task automatic test_redirect();
    logic found;
    logic [15:0] first;
    lat = 2;
    found = 0;
    first = 16'h0;
    for (int i = 0; i < 28 && !found; i++) begin
      if (i == 6) drive(1, 16'h0040, 0, 1, 0);
      else drive(0, 16'h0, 0, 1, 1);
      checks += 2;
      if ({instr_valid, instr_out, instr_pc} !== {e_iv, e_io, e_ip}) begin
        errors++;
        $display("FAIL redir_instr: got %b %h %h want %b %h %h", instr_valid, instr_out, instr_pc, e_iv, e_io, e_ip);
      end
      if ({imem_req_valid, imem_req_valid ? imem_req_addr : 16'h0} !== {e_rv, e_rv ? fpc : 16'h0}) begin
        errors++;
        $display("FAIL redir_req: got %b %h want %b %h", imem_req_valid, imem_req_addr, e_rv, fpc);
      end
      if (i > 6 && instr_valid) begin
        found = 1;
        first = instr_pc;
      end
      advance();
    end
    checks++;
    if (!found || first !== 16'h0040) begin
      errors++;
      $display("FAIL redir_first_pc: got found=%b pc %h want 1 0040", found, first);
    end
  endtask
  task automatic test_redirect_rsp();
    lat = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) drive(1, 16'h0100, 0, 1, 1);
      else drive(0, 16'h0, 0, 1, 1);
      checks += 2;
      if ({instr_valid, instr_out, instr_pc} !== {e_iv, e_io, e_ip}) begin
        errors++;
        $display("FAIL rdrsp_instr: got %b %h %h want %b %h %h", instr_valid, instr_out, instr_pc, e_iv, e_io, e_ip);
      end
      if ({imem_req_valid, imem_req_valid ? imem_req_addr : 16'h0} !== {e_rv, e_rv ? fpc : 16'h0}) begin
        errors++;
        $display("FAIL rdrsp_req: got %b %h want %b %h", imem_req_valid, imem_req_addr, e_rv, fpc);
      end
      if (i == 4) begin
        checks++;
        if (imem_req_valid !== 1'b0) begin
          errors++;
          $display("FAIL rdrsp_noreq: got req_valid %b want 0", imem_req_valid);
        end
      end
      if (i == 5) begin
        checks++;
        if (instr_valid !== 1'b0) begin
          errors++;
          $display("FAIL rdrsp_empty: got instr_valid %b want 0", instr_valid);
        end
      end
      advance();
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) lat = 1 + int'($urandom % 3);
      drive($urandom % 12 == 0, 16'($urandom), $urandom % 3 == 0, $urandom % 4 != 0, $urandom % 4 != 0);
      checks += 2;
      if ({instr_valid, instr_out, instr_pc} !== {e_iv, e_io, e_ip}) begin
        errors++;
        $display("FAIL rand_instr: got %b %h %h want %b %h %h", instr_valid, instr_out, instr_pc, e_iv, e_io, e_ip);
      end
      if ({imem_req_valid, imem_req_valid ? imem_req_addr : 16'h0} !== {e_rv, e_rv ? fpc : 16'h0}) begin
        errors++;
        $display("FAIL rand_req: got %b %h want %b %h", imem_req_valid, imem_req_addr, e_rv, fpc);
      end
      advance();
    end
  endtask
  task automatic test_reset_mid();
    drive(0, 16'h0, 1, 0, 0);
    advance();
    #1 rst = 0;
    #1;
    checks += 2;
    if ({instr_valid, instr_out, instr_pc, imem_req_valid} !== 34'h0) begin
      errors++;
      $display("FAIL midrst_out: got %b %h %h %b want all zero", instr_valid, instr_out, instr_pc, imem_req_valid);
    end
    if ({instr_valid2, instr_pc2, imem_req_valid2} !== 18'h0) begin
      errors++;
      $display("FAIL midrst_out2: got %b %h %b want all zero", instr_valid2, instr_pc2, imem_req_valid2);
    end
    #1 rst = 1;
    fifo.delete();
    inflight.delete();
    mem.delete();
    drop = 0;
    fpc = 16'h0000;
    lat = 1;
    imem_rsp_valid2 = 0;
  endtask
  task automatic test_wrap();
    logic [15:0] na, np;
    na = 16'hFFFE;
    np = 16'hFFFE;
    for (int i = 0; i < 5; i++) begin
      drive(0, 16'h0, 0, 1, 1);
      checks += 3;
      if ({instr_valid, instr_out, instr_pc} !== {e_iv, e_io, e_ip}) begin
        errors++;
        $display("FAIL restart_instr: got %b %h %h want %b %h %h", instr_valid, instr_out, instr_pc, e_iv, e_io, e_ip);
      end
      if ({imem_req_valid, imem_req_valid ? imem_req_addr : 16'h0} !== {e_rv, e_rv ? fpc : 16'h0}) begin
        errors++;
        $display("FAIL restart_req: got %b %h want %b %h", imem_req_valid, imem_req_addr, e_rv, fpc);
      end
      if ({imem_req_valid2, imem_req_addr2} !== {1'b1, na}) begin
        errors++;
        $display("FAIL wrap_addr: got %b %h want 1 %h", imem_req_valid2, imem_req_addr2, na);
      end
      na = na + 16'h0001;
      if (instr_valid2) begin
        checks++;
        if ({instr_pc2, instr_out2} !== {np, f(np)}) begin
          errors++;
          $display("FAIL wrap_instr: got pc %h data %h want %h %h", instr_pc2, instr_out2, np, f(np));
        end
        np = np + 16'h0001;
      end
      advance();
    end
    checks++;
    if (np !== 16'h0001) begin
      errors++;
      $display("FAIL wrap_count: next pc got %h want 0001", np);
    end
  endtask
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_redirect_rsp();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
